// File: rtl/gcd_lcm_engine.sv
// -----------------------------------------------------------------------------
// gcd_lcm_engine
//
// Purpose:
//   Iterative GCD / LCM engine. The GCD uses the binary (Stein) algorithm. The
//   LCM is computed as (in1 / gcd) * in2. A restoring divider and a shift-add
//   multiplier each take exactly WIDTH cycles.
//
// Ports:
//   clk   in   1        rising-edge clock for all state
//   rst   in   1        synchronous active-high reset; aborts any operation
//   GO    in   1        start request, sampled only while idle
//   mode  in   1        0 = GCD, 1 = LCM; latched on accept
//   in1   in   WIDTH    operand A; latched on accept
//   in2   in   WIDTH    operand B; latched on accept
//   out   out  2*WIDTH  result: zero-extended GCD, or full-precision LCM
//   done  out  1        result valid; held until the next accept or reset
//   busy  out  1        computation in progress
//   err   out  1        both operands were zero
// -----------------------------------------------------------------------------
module gcd_lcm_engine #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 GO,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic [2*WIDTH-1:0]   out,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StShift,
        StReduce,
        StDiv,
        StMul
    } state_e;

    // State and datapath registers
    state_e             r_state;
    logic [WIDTH-1:0]   r_a;        // Stein A; dividend/quotient in DIV; multiplier in MUL
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_k;        // common power of two removed in SHIFT
    logic [CW-1:0]      r_cnt;      // DIV / MUL step counter
    logic               r_mode;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_in2;
    logic [WIDTH-1:0]   r_g;        // GCD, used as divisor
    logic [WIDTH-1:0]   r_rem;      // divider partial remainder
    logic [2*WIDTH-1:0] r_acc;      // multiplier accumulator
    logic [2*WIDTH-1:0] r_mcand;    // multiplicand, shifted left each step
    logic               r_chk;      // second CHECK cycle
    logic               r_a_zero;
    logic               r_b_zero;
    logic [2*WIDTH-1:0] r_out;
    logic               r_done;
    logic               r_busy;
    logic               r_err;

    // Next-state values
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [CW-1:0]      w_k_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_mode_nxt;
    logic [WIDTH-1:0]   w_in1_nxt;
    logic [WIDTH-1:0]   w_in2_nxt;
    logic [WIDTH-1:0]   w_g_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_mcand_nxt;
    logic               w_chk_nxt;
    logic               w_a_zero_nxt;
    logic               w_b_zero_nxt;
    logic [2*WIDTH-1:0] w_out_nxt;
    logic               w_done_nxt;
    logic               w_busy_nxt;
    logic               w_err_nxt;

    // Datapath helpers
    logic [WIDTH-1:0]   w_g;
    logic [WIDTH-1:0]   w_a_minus_b;
    logic [WIDTH-1:0]   w_b_minus_a;
    logic [WIDTH:0]     w_trial;
    logic               w_trial_ge;
    logic [WIDTH-1:0]   w_trial_sub;
    logic [WIDTH-1:0]   w_quo_shift;
    logic [2*WIDTH-1:0] w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_add;
    logic               w_last;

    assign w_g         = r_b << r_k;
    assign w_a_minus_b = r_a - r_b;
    assign w_b_minus_a = r_b - r_a;

    // Restoring divider step: bring down the next dividend bit from r_a's MSB.
    assign w_trial     = {r_rem, r_a[WIDTH-1]};
    assign w_trial_ge  = (w_trial >= {1'b0, r_g});
    // Remainder stays below the divisor, so the difference always fits WIDTH bits.
    assign w_trial_sub = w_trial[WIDTH-1:0] - r_g;
    assign w_quo_shift = {r_a[WIDTH-2:0], w_trial_ge};

    // Shift-add multiplier step: multiplier bits consumed LSB first from r_a.
    assign w_mul_sum   = r_acc + r_mcand;
    assign w_mul_add   = r_a[0] ? w_mul_sum : r_acc;

    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_k_nxt      = r_k;
        w_cnt_nxt    = r_cnt;
        w_mode_nxt   = r_mode;
        w_in1_nxt    = r_in1;
        w_in2_nxt    = r_in2;
        w_g_nxt      = r_g;
        w_rem_nxt    = r_rem;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_chk_nxt    = r_chk;
        w_a_zero_nxt = r_a_zero;
        w_b_zero_nxt = r_b_zero;
        w_out_nxt    = r_out;
        w_done_nxt   = r_done;
        w_busy_nxt   = r_busy;
        w_err_nxt    = r_err;

        case (r_state)
            StIdle: begin
                if (GO) begin
                    w_a_nxt     = in1;
                    w_b_nxt     = in2;
                    w_in1_nxt   = in1;
                    w_in2_nxt   = in2;
                    w_mode_nxt  = mode;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_chk_nxt   = 1'b0;
                    w_state_nxt = StCheck;
                end
            end

            StCheck: begin
                // Zero flags are registered in the first cycle so the wide
                // compares never sit in front of the result mux.
                if (!r_chk) begin
                    w_chk_nxt    = 1'b1;
                    w_a_zero_nxt = (r_a == '0);
                    w_b_zero_nxt = (r_b == '0);
                end else if (r_a_zero || r_b_zero) begin
                    w_out_nxt   = r_mode ? '0 : {{WIDTH{1'b0}}, r_a | r_b};
                    w_err_nxt   = r_a_zero && r_b_zero;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = StIdle;
                end else begin
                    w_k_nxt     = '0;
                    w_state_nxt = StShift;
                end
            end

            StShift: begin
                if (!r_a[0] && !r_b[0]) begin
                    w_a_nxt = r_a >> 1;
                    w_b_nxt = r_b >> 1;
                    w_k_nxt = r_k + CW'(1);
                end else begin
                    w_state_nxt = StReduce;
                end
            end

            StReduce: begin
                if (r_a == '0) begin
                    if (!r_mode) begin
                        w_out_nxt   = {{WIDTH{1'b0}}, w_g};
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = StIdle;
                    end else begin
                        w_g_nxt     = w_g;
                        w_a_nxt     = r_in1;
                        w_rem_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StDiv;
                    end
                end else if (!r_a[0]) begin
                    w_a_nxt = r_a >> 1;
                end else if (!r_b[0]) begin
                    w_b_nxt = r_b >> 1;
                end else if (r_a >= r_b) begin
                    w_a_nxt = w_a_minus_b >> 1;
                end else begin
                    w_b_nxt = w_b_minus_a >> 1;
                end
            end

            StDiv: begin
                w_rem_nxt = w_trial_ge ? w_trial_sub : w_trial[WIDTH-1:0];
                w_a_nxt   = w_quo_shift;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    // r_a now holds the quotient and becomes the multiplier.
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_mcand_nxt = {{WIDTH{1'b0}}, r_in2};
                    w_state_nxt = StMul;
                end
            end

            StMul: begin
                w_acc_nxt   = w_mul_add;
                w_mcand_nxt = r_mcand << 1;
                w_a_nxt     = r_a >> 1;
                w_cnt_nxt   = r_cnt + CW'(1);
                if (w_last) begin
                    w_out_nxt   = w_mul_add;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_in1    <= '0;
            r_in2    <= '0;
            r_g      <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_chk    <= 1'b0;
            r_a_zero <= 1'b0;
            r_b_zero <= 1'b0;
            r_out    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_k      <= w_k_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mode   <= w_mode_nxt;
            r_in1    <= w_in1_nxt;
            r_in2    <= w_in2_nxt;
            r_g      <= w_g_nxt;
            r_rem    <= w_rem_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_chk    <= w_chk_nxt;
            r_a_zero <= w_a_zero_nxt;
            r_b_zero <= w_b_zero_nxt;
            r_out    <= w_out_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign out  = r_out;
    assign done = r_done;
    assign busy = r_busy;
    assign err  = r_err;

endmodule
